// File: rtl/dw_conv_pkg.sv
// rtl/dw_conv_pkg.sv - shared ratio, counter-width and config-check helpers for the width converters
package dw_conv_pkg;

    // Number of narrow lanes that make up one wide word.
    function automatic int unsigned conv_ratio(input int unsigned wide_dw, input int unsigned narrow_dw);
        return (narrow_dw == 0) ? 0 : wide_dw / narrow_dw;
    endfunction

    // One mask bit per lane.
    function automatic int unsigned lane_mask_width(input int unsigned wide_dw, input int unsigned narrow_dw);
        return conv_ratio(wide_dw, narrow_dw);
    endfunction

    // Lane counter width; never narrower than one bit.
    function automatic int unsigned conv_cnt_width(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    // Both converters require an integral ratio of at least two lanes.
    function automatic bit conv_cfg_ok(input int unsigned wide_dw, input int unsigned narrow_dw);
        return (narrow_dw != 0) && (wide_dw % narrow_dw == 0) && (wide_dw / narrow_dw >= 2);
    endfunction

endpackage

// File: rtl/dw_up_converter_counter.sv
// rtl/dw_up_converter_counter.sv - generic up/down counter with clear, load and overflow flag
module dw_up_converter_counter #(
    parameter int unsigned WIDTH           = 4,
    parameter bit          STICKY_OVERFLOW = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count: clear beats load beats count; overflow flags a wrap in either direction.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = STICKY_OVERFLOW ? ovf_q : 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            if (down_i) begin
                cnt_d = cnt_q - WIDTH'(1);
                if (cnt_q == '0) ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                if (&cnt_q) ovf_d = 1'b1;
            end
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o        = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/dw_up_converter.sv
// rtl/dw_up_converter.sv - packs narrow beats into wide words with lane mask and early flush
module dw_up_converter
    import dw_conv_pkg::*;
#(
    parameter int unsigned  INPUT_DW  = 64,
    parameter int unsigned  OUTPUT_DW = 512,
    localparam int unsigned UP_RATIO  = conv_ratio(OUTPUT_DW, INPUT_DW),
    localparam int unsigned CNT_WIDTH = conv_cnt_width(UP_RATIO)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [INPUT_DW-1:0]  data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [OUTPUT_DW-1:0] data_o,
    output logic [UP_RATIO-1:0]  strb_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    if (!conv_cfg_ok(OUTPUT_DW, INPUT_DW)) begin : g_cfg_check
        $fatal(1, "dw_up_converter: OUTPUT_DW must be a multiple of INPUT_DW with ratio >= 2");
    end

    typedef logic [UP_RATIO-1:0][INPUT_DW-1:0] word_t;

    word_t                 buf_q, buf_d;
    logic [UP_RATIO-1:0]   mask_q, mask_d;
    word_t                 out_q, out_d;
    logic [UP_RATIO-1:0]   strb_q, strb_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  cnt_ovf_unused;

    word_t                 word_data;
    logic [UP_RATIO-1:0]   word_strb;
    logic                  accept;
    logic                  complete;
    logic                  out_free;

    // ready_o depends only on registered state, never on ready_i.
    assign ready_o  = !pend_q;
    assign accept   = valid_i && ready_o;
    assign complete = accept && (last_i || (cnt_q == CNT_WIDTH'(UP_RATIO - 1)));
    assign out_free = !valid_q || ready_i;

    dw_up_converter_counter #(
        .WIDTH           (CNT_WIDTH),
        .STICKY_OVERFLOW (1'b0)
    ) u_lane_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (complete),
        .en_i       (accept),
        .load_i     (1'b0),
        .down_i     (1'b0),
        .d_i        ('0),
        .q_o        (cnt_q),
        .overflow_o (cnt_ovf_unused)
    );

    // Assembly buffer as it looks with the current beat merged into its lane.
    always_comb begin
        word_data = buf_q;
        word_strb = mask_q;
        if (accept) begin
            word_data[cnt_q] = data_i;
            word_strb[cnt_q] = 1'b1;
        end
    end

    // Hand completed words to the output register, or park them as pending when it is busy.
    always_comb begin
        buf_d   = word_data;
        mask_d  = word_strb;
        out_d   = out_q;
        strb_d  = strb_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            if (out_free) begin
                out_d   = word_data;
                strb_d  = word_strb;
                valid_d = 1'b1;
                buf_d   = '0;
                mask_d  = '0;
            end else begin
                pend_d  = 1'b1;
            end
        end else if (pend_q && out_free) begin
            out_d   = buf_q;
            strb_d  = mask_q;
            valid_d = 1'b1;
            pend_d  = 1'b0;
            buf_d   = '0;
            mask_d  = '0;
        end
    end

    // Assembly buffer, output register and pending flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q   <= '0;
            mask_q  <= '0;
            out_q   <= '0;
            strb_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            strb_q  <= strb_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign data_o  = out_q;
    assign strb_o  = strb_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_dw_up_converter.sv
// tb/tb_dw_up_converter.sv - directed and loopback-style checks for dw_up_converter
module tb_dw_up_converter;

    localparam int IDW = 64;
    localparam int ODW = 512;
    localparam int R   = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [IDW-1:0] data_i;
    logic           valid_i;
    logic           last_i;
    logic           ready_o;
    logic [ODW-1:0] data_o;
    logic [R-1:0]   strb_o;
    logic           valid_o;
    logic           ready_i;

    int checks   = 0;
    int failures = 0;

    logic [R+ODW-1:0] got[$];
    int               drop_cnt = 0;
    bit               watch_rdy = 1'b0;
    bit               rnd_rdy = 1'b0;

    dw_up_converter #(
        .INPUT_DW  (IDW),
        .OUTPUT_DW (ODW)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .strb_o  (strb_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change at posedge+1, so a negedge sample sees the handshake of the coming edge.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) got.push_back({strb_o, data_o});
        if (watch_rdy && !ready_o) drop_cnt++;
    end

    task automatic check(input string tag, input logic [R+ODW-1:0] obs, input logic [R+ODW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (rnd_rdy) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [IDW-1:0] d, input logic l);
        bit acc;
        int n;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        acc     = 1'b0;
        n       = 0;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = ready_o;
            step();
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        last_i  = 1'b0;
        repeat (n) step();
    endtask

    logic [ODW-1:0] w0, w1, wexp;
    logic [IDW-1:0] a_b, b_b, c_b, d_b, beat;
    logic [R+ODW-1:0] expq[$];
    int base, drops0, n;

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;

        // 1: reset state
        idle(3);
        check("rst_valid", valid_o, 0);
        check("rst_strb", strb_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ready", ready_o, 1);
        rst_ni = 1'b1;
        idle(2);
        check("post_rst_valid", valid_o, 0);

        // 2: eight back-to-back beats form one full word
        watch_rdy = 1'b1;
        drops0 = drop_cnt;
        for (int k = 0; k < R; k++) begin
            beat = 64'h1111_0000_0000_0000 + 64'(k);
            w0[k*IDW +: IDW] = beat;
            send(beat, 1'b0);
        end
        check("t2_valid", valid_o, 1);
        check("t2_word", {strb_o, data_o}, {8'hFF, w0});
        idle(1);
        check("t2_valid_pulse", valid_o, 0);
        check("t2_ready_drops", drop_cnt - drops0, 0);
        watch_rdy = 1'b0;

        // 3: early flush after three lanes, then a one-lane word
        a_b = 64'hAAAA_AAAA_0000_0001;
        b_b = 64'hBBBB_BBBB_0000_0002;
        c_b = 64'hCCCC_CCCC_0000_0003;
        d_b = 64'hDDDD_DDDD_0000_0004;
        send(a_b, 1'b0);
        send(b_b, 1'b0);
        send(c_b, 1'b1);
        wexp = '0;
        wexp[0 +: 3*IDW] = {c_b, b_b, a_b};
        check("t3_valid", valid_o, 1);
        check("t3_partial", {strb_o, data_o}, {8'h07, wexp});
        send(d_b, 1'b1);
        wexp = '0;
        wexp[0 +: IDW] = d_b;
        check("t3_one_lane", {strb_o, data_o}, {8'h01, wexp});
        for (int k = 0; k < R; k++) begin
            beat = 64'h7700 + 64'(k);
            w0[k*IDW +: IDW] = beat;
            send(beat, k == R - 1);
        end
        check("t3_last_lane7", {strb_o, data_o}, {8'hFF, w0});
        idle(2);

        // 4: backpressure with 16 beats, one word held and one pending
        ready_i = 1'b0;
        base = got.size();
        for (int k = 0; k < 2 * R; k++) begin
            beat = 64'h4444_0000_0000_0000 + 64'(k);
            if (k < R) w0[k*IDW +: IDW] = beat;
            else       w1[(k-R)*IDW +: IDW] = beat;
            send(beat, 1'b0);
        end
        check("t4_ready_low", ready_o, 0);
        check("t4_held_valid", valid_o, 1);
        check("t4_held_word", {strb_o, data_o}, {8'hFF, w0});
        idle(2);
        check("t4_still_held", {strb_o, data_o}, {8'hFF, w0});
        ready_i = 1'b1;
        idle(4);
        check("t4_count", got.size() - base, 2);
        if (got.size() - base >= 2) begin
            check("t4_word0", got[base], {8'hFF, w0});
            check("t4_word1", got[base+1], {8'hFF, w1});
        end
        check("t4_ready_back", ready_o, 1);

        // 5: 100 random full words with random downstream ready
        base = got.size();
        rnd_rdy = 1'b1;
        for (int w = 0; w < 100; w++) begin
            for (int k = 0; k < R; k++) begin
                beat = {$urandom, $urandom};
                w0[k*IDW +: IDW] = beat;
                send(beat, (k == R - 1) && w[0]);
            end
            expq.push_back({8'hFF, w0});
        end
        n = 0;
        valid_i = 1'b0;
        while (got.size() - base < 100 && n < 3000) begin
            idle(1);
            n++;
        end
        rnd_rdy = 1'b0;
        ready_i = 1'b1;
        idle(3);
        check("t5_count", got.size() - base, 100);
        for (int w = 0; w < 100; w++) begin
            if (base + w < got.size()) check($sformatf("t5_word%0d", w), got[base+w], expq[w]);
        end

        // 6: reset in the middle of a word
        for (int k = 0; k < 4; k++) send(64'h5555_0000_0000_0000 + 64'(k), 1'b0);
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        #2;
        check("t6_rst_valid", valid_o, 0);
        check("t6_rst_ready", ready_o, 1);
        idle(2);
        rst_ni = 1'b1;
        idle(1);
        base = got.size();
        for (int k = 0; k < R; k++) begin
            beat = 64'h6666_0000_0000_0000 + 64'(k);
            w0[k*IDW +: IDW] = beat;
            send(beat, 1'b0);
        end
        idle(3);
        check("t6_count", got.size() - base, 1);
        if (got.size() > base) check("t6_clean_word", got[base], {8'hFF, w0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dw_up_converter.md
Name: dw_up_converter

Overview:
Width up-converter: packs a stream of narrow INPUT_DW beats into OUTPUT_DW words, lane 0 in the LSBs. It is the counterpart of the down-converter and sits downstream of it on the narrow AXI-side data path, rebuilding wide words for the XDMA datapath. An optional last_i flushes a partial word early. A lane-valid mask marks which lanes carry data. The assembly buffer and output register are double-buffered, so the block runs at one beat per cycle under ready_i=1.

Parameters:
INPUT_DW, 64, width of the narrow input beat
OUTPUT_DW, 512, width of the wide output word; must be an integer multiple of INPUT_DW
UP_RATIO, OUTPUT_DW/INPUT_DW, number of lanes per word; derived, do not override; must be >= 2
CNT_WIDTH, $clog2(UP_RATIO), width of the lane counter; derived, do not override

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
data_i  input  INPUT_DW  narrow input beat
valid_i  input  1  input beat valid
last_i  input  1  the beat is the final beat of a word; flush after it (sampled with valid_i)
ready_o  output  1  input beat accepted when valid_i && ready_o
data_o  output  OUTPUT_DW  assembled wide word
strb_o  output  UP_RATIO  lane-valid mask; bit k covers data_o[k*INPUT_DW +: INPUT_DW]
valid_o  output  1  output word valid
ready_i  input  1  downstream ready

Behaviour:
- Reset is rst_ni, asynchronous, active-low, on clock clk_i.
- Reset values: valid_o=0, data_o=0, strb_o=0, ready_o=1. The lane counter is 0, the assembly buffer and mask are 0, and the pending flag pend_q is 0.
- Accept: on valid_i && ready_o, data_i is written to lane cnt_q of the assembly buffer and mask bit cnt_q is set. cnt_q then increments.
- A word completes on an accepted beat with cnt_q == UP_RATIO-1 or last_i=1. On completion:
  - cnt_q returns to 0.
  - The next accepted beat starts a new word at lane 0 with a clean mask.
- Transfer of a completed word into the output register happens when the output register is free: valid_o=0, or valid_o && ready_i in the same cycle.
  - If the register is free at completion, the word is loaded at the same clock edge. valid_o rises the cycle after the final beat is accepted (latency 1 cycle).
  - If the register is not free, the word stays in the assembly buffer and pend_q=1.
- ready_o = !pend_q. Combinational path from ready_i to ready_o is forbidden.
- While pend_q=1: the word moves to the output register on the first cycle it is free. pend_q clears at that edge, and ready_o returns to 1 the following cycle.
- While a completed word is being transferred, the assembly buffer and mask are cleared. A beat accepted in the same cycle lands in lane 0 of the new word.
- Output hold: data_o, strb_o and valid_o stay stable while valid_o && !ready_i. Unused lanes of a partial word are driven 0.
- The order of output words equals the order in which they completed. No word is dropped or duplicated.
- Throughput: with ready_i held at 1, valid_i held at 1 and no last_i, one word is emitted every UP_RATIO cycles and ready_o never drops.
- Boundary, last_i on lane 0: a 1-lane word is emitted with strb_o = 1.
- Boundary, last_i on lane UP_RATIO-1: identical to a natural full completion.
- Boundary, last_i while pend_q=1: not possible, since no beat is accepted.
- Reset mid-word: the partial word and any pending or output word are discarded. The first beat after reset goes to lane 0.
- Elaboration asserts: OUTPUT_DW % INPUT_DW == 0 and UP_RATIO >= 2; $fatal otherwise.

Decomposition:
- Shared package dw_conv_pkg: lane-mask width helper, ratio and counter-width computation, and a common elaboration-check function used by both converters.
- Sub-module: reuse the existing counter (WIDTH=CNT_WIDTH, STICKY_OVERFLOW=0) as the lane counter.
  - en_i = beat accepted.
  - clear_i = word completion.
  - load_i = 0, down_i = 0.
- Everything else stays inline: assembly buffer, output register, pend_q.

Test Plan:
1. Reset with valid_i=0 -> valid_o=0, strb_o=0x00, data_o=0, ready_o=1.
2. 8 consecutive beats, beat k = 64'h1111_0000_0000_0000 + k, ready_i=1 -> valid_o=1 for one cycle, one cycle after beat 7. Lane k = beat k, strb_o=0xFF, ready_o stays 1.
3. 3 beats (A,B,C) with last_i on C, ready_i=1 -> strb_o=0x07, lanes 0..2 = A,B,C, lanes 3..7 = 0. The following beat lands in lane 0.
4. ready_i=0, 16 beats offered back to back:
   - word 0 is held on the output, word 1 is assembled, pend_q=1, ready_o=0 after beat 16.
   - ready_i=1 -> word 0 then word 1 emitted in order, ready_o=1 again, no beat lost.
5. Loopback through dw_down_converter(512->64) -> dw_up_converter(64->512), 100 random words, random ready_i toggling -> output equals input word-for-word, strb_o=0xFF.
6. Assert rst_ni low after 4 beats of a word -> no valid_o. Next 8 beats form a clean word with strb_o=0xFF and lane 0 = the first post-reset beat.
